operand_stack: RTL and testbench

Parametrised LIFO operand store for the calculator datapath. It generalises the single operand register into a configurable-width, configurable-depth stack with push, pop, replace and clear operations. Top-of-stack and next-of-stack are always visible to the ALU, and occupancy and error status are visible to the control FSM.

---
 rtl/operand_stack.sv | 140 ++++++++++++++
 tb/tb_operand_stack.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stack.sv
// operand_stack: parametrised LIFO operand store with push, pop, replace and clear.
// The Overflow/Underflow status registers exist only when OPERAND_STACK_ERRFLAGS_EN
// is defined. Otherwise both outputs are tied to 0, and data/Count behaviour is unchanged.
module operand_stack #(
    parameter int unsigned Word_Length = 4,
    parameter int unsigned Depth       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [Word_Length-1:0]       Data_Input,
    output logic [Word_Length-1:0]       Top_Output,
    output logic [Word_Length-1:0]       Second_Output,
    output logic [$clog2(Depth+1)-1:0]   Count,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int unsigned CW = $clog2(Depth + 1);
    localparam int unsigned AW = $clog2(Depth);

    logic [Word_Length-1:0] mem_q [Depth];
    logic [CW-1:0]          count_q, count_d;
    logic                   wr_en;
    logic [AW-1:0]          wr_idx;
    logic                   full_c, empty_c;
`ifdef OPERAND_STACK_ERRFLAGS_EN
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
`endif

    assign full_c  = (count_q == CW'(Depth));
    assign empty_c = (count_q == '0);

    // Next-state decode: clear wins, then the {push,pop} operation table.
    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
`ifdef OPERAND_STACK_ERRFLAGS_EN
        ovf_d   = ovf_q;
        unf_d   = unf_q;
`endif
        if (clear) begin
            count_d = '0;
`ifdef OPERAND_STACK_ERRFLAGS_EN
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
`endif
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (!full_c) begin
                        wr_en   = 1'b1;
                        wr_idx  = AW'(count_q);
                        count_d = count_q + CW'(1);
                    end else begin
`ifdef OPERAND_STACK_ERRFLAGS_EN
                        ovf_d = 1'b1;
`endif
                    end
                end
                2'b01: begin
                    if (!empty_c) begin
                        count_d = count_q - CW'(1);
                    end else begin
`ifdef OPERAND_STACK_ERRFLAGS_EN
                        unf_d = 1'b1;
`endif
                    end
                end
                2'b11: begin
                    wr_en = 1'b1;
                    if (!empty_c) begin
                        // Replace the top in place; legal even when full.
                        wr_idx = AW'(count_q - CW'(1));
                    end else begin
                        wr_idx  = '0;
                        count_d = CW'(1);
`ifdef OPERAND_STACK_ERRFLAGS_EN
                        unf_d   = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers: the entry array, the count and, if built, the sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
`ifdef OPERAND_STACK_ERRFLAGS_EN
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                mem_q[wr_idx] <= Data_Input;
            end
            count_q <= count_d;
`ifdef OPERAND_STACK_ERRFLAGS_EN
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`endif
        end
    end

    // Output reads of registered state. Entries that are not valid read as 0.
    always_comb begin
        Top_Output    = '0;
        Second_Output = '0;
        if (!empty_c) begin
            Top_Output = mem_q[AW'(count_q - CW'(1))];
        end
        if (count_q >= CW'(2)) begin
            Second_Output = mem_q[AW'(count_q - CW'(2))];
        end
    end

    assign Count = count_q;
    assign Full  = full_c;
    assign Empty = empty_c;
`ifdef OPERAND_STACK_ERRFLAGS_EN
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
`else
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: checks two operand_stack instances (default 4x8 and 6x2)
// against a queue-based reference model, using directed and random stimulus.
module tb_operand_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance 0: Word_Length=4, Depth=8
    logic       cl0, pu0, po0;
    logic [3:0] di0;
    logic [3:0] t0, s0, n0;
    logic       f0, e0, o0, u0;
    logic [15:0] obs0;
    assign obs0 = {t0, s0, n0, f0, e0, o0, u0};

    // Instance 1: Word_Length=6, Depth=2
    logic       cl1, pu1, po1;
    logic [5:0] di1;
    logic [5:0] t1, s1;
    logic [1:0] n1;
    logic       f1, e1, o1, u1;
    logic [17:0] obs1;
    assign obs1 = {t1, s1, n1, f1, e1, o1, u1};

    operand_stack #(.Word_Length(4), .Depth(8)) dut0 (
        .clk(clk), .reset(reset), .clear(cl0), .push(pu0), .pop(po0),
        .Data_Input(di0), .Top_Output(t0), .Second_Output(s0), .Count(n0),
        .Full(f0), .Empty(e0), .Overflow(o0), .Underflow(u0)
    );

    operand_stack #(.Word_Length(6), .Depth(2)) dut1 (
        .clk(clk), .reset(reset), .clear(cl1), .push(pu1), .pop(po1),
        .Data_Input(di1), .Top_Output(t1), .Second_Output(s1), .Count(n1),
        .Full(f1), .Empty(e1), .Overflow(o1), .Underflow(u1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a queue whose last element is the top of stack.
    logic [3:0] m0[$];
    logic       m0_ovf, m0_unf;
    logic [5:0] m1[$];
    logic       m1_ovf, m1_unf;

    task automatic mdl0(input logic pu, input logic po, input logic cl, input logic [3:0] d);
        if (cl) begin
            m0.delete(); m0_ovf = 1'b0; m0_unf = 1'b0;
        end else if (pu && po) begin
            if (m0.size() == 0) begin m0.push_back(d); m0_unf = 1'b1; end
            else m0[m0.size()-1] = d;
        end else if (pu) begin
            if (m0.size() < 8) m0.push_back(d); else m0_ovf = 1'b1;
        end else if (po) begin
            if (m0.size() > 0) void'(m0.pop_back()); else m0_unf = 1'b1;
        end
    endtask

    task automatic mdl1(input logic pu, input logic po, input logic cl, input logic [5:0] d);
        if (cl) begin
            m1.delete(); m1_ovf = 1'b0; m1_unf = 1'b0;
        end else if (pu && po) begin
            if (m1.size() == 0) begin m1.push_back(d); m1_unf = 1'b1; end
            else m1[m1.size()-1] = d;
        end else if (pu) begin
            if (m1.size() < 2) m1.push_back(d); else m1_ovf = 1'b1;
        end else if (po) begin
            if (m1.size() > 0) void'(m1.pop_back()); else m1_unf = 1'b1;
        end
    endtask

    function automatic logic [15:0] exp0();
        int sz = m0.size();
        logic [3:0] t = (sz >= 1) ? m0[sz-1] : 4'd0;
        logic [3:0] s = (sz >= 2) ? m0[sz-2] : 4'd0;
        logic eo = 1'b0, eu = 1'b0;
`ifdef OPERAND_STACK_ERRFLAGS_EN
        eo = m0_ovf; eu = m0_unf;
`endif
        return {t, s, 4'(sz), (sz == 8), (sz == 0), eo, eu};
    endfunction

    function automatic logic [17:0] exp1();
        int sz = m1.size();
        logic [5:0] t = (sz >= 1) ? m1[sz-1] : 6'd0;
        logic [5:0] s = (sz >= 2) ? m1[sz-2] : 6'd0;
        logic eo = 1'b0, eu = 1'b0;
`ifdef OPERAND_STACK_ERRFLAGS_EN
        eo = m1_ovf; eu = m1_unf;
`endif
        return {t, s, 2'(sz), (sz == 2), (sz == 0), eo, eu};
    endfunction

    function automatic logic exp_flag(input logic f);
`ifdef OPERAND_STACK_ERRFLAGS_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle of an operation on instance 0, inputs returned to idle afterwards.
    task automatic op0(input logic pu, input logic po, input logic cl, input logic [3:0] d);
        pu0 = pu; po0 = po; cl0 = cl; di0 = d;
        @(posedge clk); #1;
        mdl0(pu, po, cl, d);
        pu0 = 1'b0; po0 = 1'b0; cl0 = 1'b0;
    endtask

    task automatic op1(input logic pu, input logic po, input logic cl, input logic [5:0] d);
        pu1 = pu; po1 = po; cl1 = cl; di1 = d;
        @(posedge clk); #1;
        mdl1(pu, po, cl, d);
        pu1 = 1'b0; po1 = 1'b0; cl1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pu0 = 0; po0 = 0; cl0 = 0; di0 = 0;
        pu1 = 0; po1 = 0; cl1 = 0; di1 = 0;
        mdl0(0, 0, 1, 0); mdl1(0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs0 !== 16'h0004) begin bad++; $display("FAIL reset0 got=%h want=%h", obs0, 16'h0004); end
        total++;
        if (obs1 !== 18'h00004) begin bad++; $display("FAIL reset1 got=%h want=%h", obs1, 18'h00004); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_push_pop();
        op0(1, 0, 0, 4'd3); op0(1, 0, 0, 4'd5); op0(1, 0, 0, 4'd9);
        total++;
        if ({n0, t0, s0, e0} !== {4'd3, 4'd9, 4'd5, 1'b0}) begin
            bad++; $display("FAIL push3 got cnt=%0d top=%0d sec=%0d emp=%b want 3 9 5 0", n0, t0, s0, e0);
        end
        op0(0, 1, 0, 4'd0); op0(0, 1, 0, 4'd0);
        total++;
        if ({n0, t0, s0} !== {4'd1, 4'd3, 4'd0}) begin
            bad++; $display("FAIL pop2 got cnt=%0d top=%0d sec=%0d want 1 3 0", n0, t0, s0);
        end
        op0(0, 1, 0, 4'd0);
        total++;
        if ({n0, e0, t0} !== {4'd0, 1'b1, 4'd0}) begin
            bad++; $display("FAIL pop_last got cnt=%0d emp=%b top=%0d want 0 1 0", n0, e0, t0);
        end
        op0(0, 1, 0, 4'd0);
        total++;
        if ({n0, u0} !== {4'd0, exp_flag(1'b1)}) begin
            bad++; $display("FAIL underflow got cnt=%0d unf=%b want 0 %b", n0, u0, exp_flag(1'b1));
        end
        total++;
        if (obs0 !== exp0()) begin bad++; $display("FAIL pop_model got=%h want=%h", obs0, exp0()); end
    endtask

    task automatic test_full_overflow();
        op0(0, 0, 1, 4'd0);
        for (int i = 1; i <= 8; i++) op0(1, 0, 0, 4'(i));
        total++;
        if ({f0, n0, t0} !== {1'b1, 4'd8, 4'd8}) begin
            bad++; $display("FAIL fill got full=%b cnt=%0d top=%0d want 1 8 8", f0, n0, t0);
        end
        op0(1, 0, 0, 4'd15);
        total++;
        if ({n0, t0, o0} !== {4'd8, 4'd8, exp_flag(1'b1)}) begin
            bad++; $display("FAIL overflow got cnt=%0d top=%0d ovf=%b want 8 8 %b", n0, t0, o0, exp_flag(1'b1));
        end
        op0(1, 1, 0, 4'd12);
        total++;
        if ({t0, n0, s0} !== {4'd12, 4'd8, 4'd7}) begin
            bad++; $display("FAIL replace_full got top=%0d cnt=%0d sec=%0d want 12 8 7", t0, n0, s0);
        end
        total++;
        if (obs0 !== exp0()) begin bad++; $display("FAIL full_model got=%h want=%h", obs0, exp0()); end
    endtask

    task automatic test_replace_clear();
        op0(0, 0, 1, 4'd0);
        op0(1, 1, 0, 4'd6);
        total++;
        if ({n0, t0, u0} !== {4'd1, 4'd6, exp_flag(1'b1)}) begin
            bad++; $display("FAIL pushpop_empty got cnt=%0d top=%0d unf=%b want 1 6 %b", n0, t0, u0, exp_flag(1'b1));
        end
        op0(1, 0, 1, 4'd9);
        total++;
        if (obs0 !== 16'h0004) begin bad++; $display("FAIL clear_wins got=%h want=%h", obs0, 16'h0004); end
    endtask

    task automatic test_async_reset();
        op0(1, 0, 0, 4'd7); op0(1, 0, 0, 4'd2);
        pu0 = 1'b1; di0 = 4'hA;
        #2;
        reset = 1'b0;
        #1;
        mdl0(0, 0, 1, 0); mdl1(0, 0, 1, 0);
        total++;
        if (obs0 !== 16'h0004) begin bad++; $display("FAIL async_reset got=%h want=%h", obs0, 16'h0004); end
        pu0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        op0(1, 0, 0, 4'd4);
        total++;
        if ({n0, t0} !== {4'd1, 4'd4}) begin
            bad++; $display("FAIL after_reset got cnt=%0d top=%0d want 1 4", n0, t0);
        end
    endtask

    task automatic test_small_config();
        op1(1, 0, 0, 6'd63); op1(1, 0, 0, 6'd0);
        total++;
        if ({t1, s1, f1} !== {6'd0, 6'd63, 1'b1}) begin
            bad++; $display("FAIL small_fill got top=%0d sec=%0d full=%b want 0 63 1", t1, s1, f1);
        end
        op1(0, 1, 0, 6'd0);
        total++;
        if ({t1, s1} !== {6'd63, 6'd0}) begin
            bad++; $display("FAIL small_pop got top=%0d sec=%0d want 63 0", t1, s1);
        end
        total++;
        if (obs1 !== exp1()) begin bad++; $display("FAIL small_model got=%h want=%h", obs1, exp1()); end
    endtask

    // Random back-to-back operations on both instances, compared every cycle.
    task automatic test_random();
        int fails0 = 0, fails1 = 0;
        for (int i = 0; i < 600; i++) begin
            logic a, b, c, x, y, z;
            logic [3:0] r0;
            logic [5:0] r1;
            if (i < 300) begin
                a = ($urandom_range(0, 2) != 0); b = ($urandom_range(0, 3) == 0);
            end else begin
                a = ($urandom_range(0, 3) == 0); b = ($urandom_range(0, 2) != 0);
            end
            c = ($urandom_range(0, 40) == 0);
            x = $urandom_range(0, 1); y = $urandom_range(0, 1);
            z = ($urandom_range(0, 30) == 0);
            r0 = 4'($urandom); r1 = 6'($urandom);
            pu0 = a; po0 = b; cl0 = c; di0 = r0;
            pu1 = x; po1 = y; cl1 = z; di1 = r1;
            @(posedge clk); #1;
            mdl0(a, b, c, r0);
            mdl1(x, y, z, r1);
            total++;
            if (obs0 !== exp0()) begin
                bad++;
                if (fails0 < 5) $display("FAIL rand0 cyc=%0d got=%h want=%h", i, obs0, exp0());
                fails0++;
            end
            total++;
            if (obs1 !== exp1()) begin
                bad++;
                if (fails1 < 5) $display("FAIL rand1 cyc=%0d got=%h want=%h", i, obs1, exp1());
                fails1++;
            end
        end
        pu0 = 0; po0 = 0; cl0 = 0; pu1 = 0; po1 = 0; cl1 = 0;
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_full_overflow();
        test_replace_clear();
        test_async_reset();
        test_small_config();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
